// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rd_state_t;

endpackage

// File: rtl/axi_lite_wr_fsm.sv
// Write-side AW/W capture in either order, B response and commit strobe.
// state       | meaning
// W_IDLE      | nothing captured, AW and W both ready
// W_HAVE_ADDR | address captured, waiting for W
// W_HAVE_DATA | data/strobe captured, waiting for AW
// W_RESP      | write committed, holding bvalid until bready
module axi_lite_wr_fsm
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic                    commit_o,
  output logic                    commit_ok_o,
  output logic [ADDR_WIDTH-1:0]   commit_idx_o,
  output logic [DATA_WIDTH-1:0]   commit_data_o,
  output logic [DATA_WIDTH/8-1:0] commit_strb_o
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);

  wr_state_t               state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;

  logic                    aw_fire, w_fire, have_addr, have_data;
  logic [ADDR_WIDTH-1:0]   addr_eff;

  assign aw_fire   = awvalid_i && awready_q;
  assign w_fire    = wvalid_i && wready_q;
  assign have_addr = aw_fire || (state_q == W_HAVE_ADDR);
  assign have_data = w_fire || (state_q == W_HAVE_DATA);

  // A handshake in the completing cycle is used directly, so the commit
  // lands on the same edge that finishes the second handshake.
  assign addr_eff      = aw_fire ? awaddr_i : addr_q;
  assign commit_o      = have_addr && have_data;
  assign commit_idx_o  = addr_eff >> ADDR_LSB;
  assign commit_ok_o   = 32'(commit_idx_o) < NUM_REGS;
  assign commit_data_o = w_fire ? wdata_i : data_q;
  assign commit_strb_o = w_fire ? wstrb_i : strb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_fire) addr_q <= awaddr_i;
      if (w_fire) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
      case (state_q)
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA: begin
          if (commit_o) begin
            state_q   <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= commit_ok_o ? RESP_OKAY : RESP_SLVERR;
          end else if (have_addr) begin
            state_q   <= W_HAVE_ADDR;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (have_data) begin
            state_q   <= W_HAVE_DATA;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            state_q   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite register bank: register array, read channel and
// fabric-facing register/write-pulse outputs.
// state   | meaning
// R_IDLE  | arready high, waiting for AR
// R_VALID | rdata/rresp held until rready
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int STRB_W   = DATA_WIDTH / 8;

  logic                  commit, commit_ok;
  logic [ADDR_WIDTH-1:0] commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;

  axi_lite_wr_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_wr_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .awaddr_i     (awaddr),
    .awvalid_i    (awvalid),
    .awready_o    (awready),
    .wdata_i      (wdata),
    .wstrb_i      (wstrb),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .bresp_o      (bresp),
    .bvalid_o     (bvalid),
    .bready_i     (bready),
    .commit_o     (commit),
    .commit_ok_o  (commit_ok),
    .commit_idx_o (commit_idx),
    .commit_data_o(commit_data),
    .commit_strb_o(commit_strb)
  );

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  // Pulse fires on any in-range commit, including an all-zero strobe.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && commit_ok && (commit_idx == ADDR_WIDTH'(i))) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++)
          if (commit_strb[b]) regs_d[i][b*8 +: 8] = commit_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
  assign wr_pulse_o = wr_pulse_q;

  rd_state_t             rd_state_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_data;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_ok;

  assign rd_idx = araddr >> ADDR_LSB;
  assign rd_ok  = 32'(rd_idx) < NUM_REGS;

  // Reads sample regs_q, so a same-edge write is seen only by later reads.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == ADDR_WIDTH'(i)) rd_data = regs_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (arvalid) begin
            rd_state_q <= R_VALID;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_ok ? rd_data : '0;
            rresp_q    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_VALID: begin
          if (rready) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule
